count_capture_fifo: RTL and testbench
=====================================

# count_capture_fifo

Timestamp capture stage that sits directly downstream of the counter. On each qualified edge of an external event input it snapshots the counter's `count` value into a DEPTH-entry FIFO. The management SoC drains the FIFO over the same valid/ready register handshake the counter uses. An interrupt is raised while captured timestamps are pending.

## Interface
Parameters:
- `BITS`, default 16: width of `count` and of each stored timestamp.
- `DEPTH`, default 8: FIFO entries; must be a power of 2, at least 2.
- `SYNC_STAGES`, default 2: synchroniser flops on `event_in`; at least 2.

Ports:
- `clk`  in  1: single clock, the same clock as the counter.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `count`  in  BITS: free-running count from the counter.
- `event_in`  in  1: asynchronous event pin, typically an `io_in` bit.
- `valid`  in  1: bus request; held until `ready`.
- `addr`  in  2: register select; 0 = DATA, 1 = STATUS, 2 = CTRL, 3 = reserved.
- `wstrb`  in  4: byte write strobes; all zero means read.
- `wdata`  in  32: write data.
- `ready`  out  1: one-cycle acknowledge.
- `rdata`  out  32: read data, valid while `ready` = 1.
- `irq`  out  1: pending-capture interrupt, registered.

## Operation
- **CTRL (R/W, byte 0):**
  - bit0 `enable`
  - bits2:1 `edge_sel`: 01 = rising, 10 = falling, 11 = both, 00 = none
  - bit3 `irq_en`
  - all other bits read 0
- **STATUS (R; write-1-to-clear on bit31):**
  - bits[log2(DEPTH):0] `level`, range 0..DEPTH
  - bit16 `empty`
  - bit17 `full`
  - bit31 `overflow`, sticky
- **DATA (R):** a read returns the oldest entry zero-extended to 32 bits and pops it. A read while empty returns 0, does not pop and does not flag an error. Writes to DATA and to addr 3 are acknowledged and ignored.
- **Event path:**
  - `event_in` passes through SYNC_STAGES flops, then one delay flop for edge compare.
  - An edge qualifies when `enable` = 1 and its polarity matches `edge_sel`.
- **Push:** a qualified edge writes `count` into the FIFO.
  - If full and no pop in the same cycle, the event is dropped and `overflow` is set.
  - If full and a pop occurs in the same cycle, the push is accepted; `level` stays at DEPTH and `overflow` is not set.
- **Simultaneous push and pop when not empty:** both happen and `level` is unchanged.
- **Simultaneous push and pop when empty:** the DATA read returns 0 and the pushed entry is stored; `level` becomes 1.
- **Overflow clear vs set:** an overflow set and a W1C in the same cycle leaves `overflow` = 1 (set wins).
- **Pointers:** log2(DEPTH)+1 bits each; they wrap modulo 2*DEPTH, so full and empty are distinguished by the MSB.
- **Bus handshake:** the request is accepted when `valid` && !`ready`.
  - On the next edge, `ready` = 1 for exactly one cycle, and `rdata`, pop and register write all take effect on that edge.
  - A back-to-back request gets its next `ready` no earlier than 2 cycles later.
- **irq:** `irq` <= `irq_en` & !`empty`, registered.
- **Reset values:**
  - outputs: `ready` 0, `rdata` 0, `irq` 0
  - state: CTRL 0, pointers 0 (empty), `overflow` 0, synchroniser and delay flops 0
  - FIFO storage is not reset.

## Timing
- E0 is the first `clk` edge that samples a new `event_in` level.
  - The FIFO write happens at E0+SYNC_STAGES.
  - The stored value is the `count` present just before that edge.
  - `level` and `empty` update after that edge, and `irq` one edge later.
- Read latency: `ready`/`rdata` appear 1 cycle after `valid` is first seen.
  - `level` reflects the pop in the same cycle that `ready` is high.
- CTRL changes take effect for edges detected in the cycle after the write.
  - If `enable` is cleared, edges already in the synchroniser but not yet compared are discarded.
  - On re-enable, the synchroniser and delay flops keep tracking `event_in`, so no false edge is generated.
- Reset asserted mid-operation (including between `valid` and `ready`):
  - all state clears immediately; no `ready` is issued for the aborted access.
  - after deassertion the master must re-issue the request.

## Test plan
- **Capture ordering:** reset, CTRL=0x3 (rising), `count` ramps from 0x0100, three rising edges spaced 5 cycles apart -> STATUS `level`=3; three DATA reads return ascending values, each equal to `count` at E0+2; `empty`=1 afterwards.
- **Edge select:** `edge_sel`=10, pulse `event_in` high 4 cycles -> exactly 1 entry, taken on the falling edge; `edge_sel`=11 with the same pulse -> 2 entries; `edge_sel`=00 -> 0 entries.
- **Overflow:** DEPTH=8, 10 rising edges with no reads -> `level`=8, `full`=1, `overflow`=1; the 8 entries read back are the first 8 timestamps; writing STATUS 0x8000_0000 clears `overflow`.
- **Full with simultaneous push and pop:** FIFO full, DATA read acknowledged on the same edge as a push -> `level` stays 8, `overflow` stays 0, newest entry retained.
- **Empty read and irq:** read DATA while empty -> `rdata`=0, `level`=0; with `irq_en`=1, one capture -> `irq` goes to 1 at E0+3 and returns to 0 the cycle after the popping read.
- **Reset mid-access:** assert `reset` while `valid`=1 before `ready` -> `ready` never pulses, all outputs are 0, STATUS reads `empty`=1 and `overflow`=0 after the request is re-issued.

Source files
------------

// File: rtl/count_capture_fifo_if.sv
// Register bus between the management SoC and the capture FIFO.
// The master holds valid until it sees ready; the slave acknowledges with a one-cycle ready.
interface count_capture_fifo_if;
  logic        valid;
  logic [1:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/count_capture_fifo.sv
// Snapshots count on qualified event_in edges into a DEPTH-entry FIFO drained over the register bus.
// Capture lands SYNC_STAGES cycles after the pin is sampled; bus ack 1 cycle after valid; full FIFO drops events and sets overflow.
module count_capture_fifo #(
  parameter int BITS        = 16,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BITS-1:0]       count,
  input  logic                  event_in,
  count_capture_fifo_if.slave   bus,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic [3:0]             ctrl_q, ctrl_d;
  ptr_t                   wptr_q, wptr_d, rptr_q, rptr_d;
  logic                   ovf_q, ovf_d;
  logic                   ready_q, ready_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   irq_q, irq_d;
  logic [BITS-1:0]        mem_q [DEPTH];

  logic        sync_out, rise, fall, push_req, empty, full;
  logic        accept, is_wr, pop, push;
  ptr_t        level;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^bus.wdata[30:4];

  always_comb begin
    sync_out = sync_q[SYNC_STAGES-1];
    rise     = sync_out & ~dly_q;
    fall     = ~sync_out & dly_q;
    push_req = ctrl_q[0] & ((rise & ctrl_q[1]) | (fall & ctrl_q[2]));
    level    = wptr_q - rptr_q;
    empty    = (wptr_q == rptr_q);
    full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    accept   = bus.valid & ~ready_q;
    is_wr    = |bus.wstrb;
    pop      = accept & ~is_wr & (bus.addr == 2'd0) & ~empty;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push     = push_req & (~full | pop);
    status         = '0;
    status[AW:0]   = level;
    status[16]     = empty;
    status[17]     = full;
    status[31]     = ovf_q;
  end

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], event_in};
    dly_d   = sync_out;
    ctrl_d  = ctrl_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q + ptr_t'(push);
    rptr_d  = rptr_q + ptr_t'(pop);
    ready_d = accept;
    rdata_d = '0;
    irq_d   = ctrl_q[3] & ~empty;
    if (accept) begin
      if (is_wr) begin
        if (bus.addr == 2'd2 && bus.wstrb[0]) ctrl_d = bus.wdata[3:0];
        if (bus.addr == 2'd1 && bus.wstrb[3] && bus.wdata[31]) ovf_d = 1'b0;
      end else begin
        case (bus.addr)
          2'd0:    rdata_d = empty ? '0 : 32'(mem_q[rptr_q[AW-1:0]]);
          2'd1:    rdata_d = status;
          2'd2:    rdata_d = {28'b0, ctrl_q};
          default: rdata_d = '0;
        endcase
      end
    end
    // Set is applied after the W1C so a same-cycle overflow is not lost.
    if (push_req & full & ~pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      ctrl_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      ctrl_q  <= ctrl_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= count;
  end

  assign bus.ready = ready_q;
  assign bus.rdata = rdata_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Bench for count_capture_fifo: queue-based reference model feeds a scoreboard checked by a free-running monitor.
module tb_count_capture_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] count = 16'h0100;
  logic        event_in = 1'b0;
  logic        irq;

  count_capture_fifo_if bif();

  count_capture_fifo #(.BITS(16), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .count(count), .event_in(event_in), .bus(bif), .irq(irq)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (!reset) count = count + 16'd1;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: captured timestamps as a queue, pending pin edges tagged with the cycle they land.
  logic [15:0] mq[$];
  logic [31:0] exp_q[$];
  bit          cmp_q[$];
  int          due_q[$];
  bit          rise_q[$];
  logic [3:0]  m_ctrl = 4'h0;
  bit          m_ovf = 0, m_ready = 0, m_irq = 0, prev_ev = 0;
  int          k = 0;

  always @(posedge clk) begin : model
    bit ovf_set, irq_nx, rs;
    logic [3:0]  ctrl_now;
    logic [31:0] r;
    if (reset) begin
      mq.delete(); exp_q.delete(); cmp_q.delete(); due_q.delete(); rise_q.delete();
      m_ctrl = 4'h0; m_ovf = 0; m_ready = 0; m_irq = 0; prev_ev = 0; k = 0;
    end else begin
      ctrl_now = m_ctrl;
      irq_nx   = m_ctrl[3] && (mq.size() != 0);
      ovf_set  = 0;
      if (bif.valid && !m_ready) begin
        r = 32'h0;
        if (bif.wstrb == 4'h0) begin
          case (bif.addr)
            2'd0: if (mq.size() != 0) r = 32'(mq.pop_front());
            2'd1: begin
              r[3:0] = 4'(mq.size());
              r[16]  = (mq.size() == 0);
              r[17]  = (mq.size() == DEPTH);
              r[31]  = m_ovf;
            end
            2'd2: r = {28'b0, m_ctrl};
            default: ;
          endcase
          exp_q.push_back(r); cmp_q.push_back(bif.addr != 2'd3);
        end else begin
          exp_q.push_back(32'h0); cmp_q.push_back(0);
          if (bif.addr == 2'd2 && bif.wstrb[0]) m_ctrl = bif.wdata[3:0];
          if (bif.addr == 2'd1 && bif.wstrb[3] && bif.wdata[31]) m_ovf = 0;
        end
        m_ready = 1;
      end else begin
        m_ready = 0;
      end
      while (due_q.size() != 0 && due_q[0] == k) begin
        void'(due_q.pop_front());
        rs = rise_q.pop_front();
        if (ctrl_now[0] && (rs ? ctrl_now[1] : ctrl_now[2])) begin
          if (mq.size() < DEPTH) mq.push_back(count);
          else ovf_set = 1;
        end
      end
      if (ovf_set) m_ovf = 1;
      if (event_in != prev_ev) begin
        due_q.push_back(k + 2); rise_q.push_back(event_in); prev_ev = event_in;
      end
      m_irq = irq_nx;
      k++;
    end
  end

  logic [31:0] e_val;
  bit          e_cmp;

  always @(posedge clk) begin : monitor
    #1;
    checks++;
    if (bif.ready !== m_ready) begin
      errors++; $display("FAIL ready got=%b exp=%b t=%0t", bif.ready, m_ready, $time);
    end
    checks++;
    if (irq !== m_irq) begin
      errors++; $display("FAIL irq got=%b exp=%b t=%0t", irq, m_irq, $time);
    end
    if (m_ready && exp_q.size() != 0) begin
      e_val = exp_q.pop_front();
      e_cmp = cmp_q.pop_front();
      if (e_cmp && bif.ready === 1'b1) begin
        checks++;
        if (bif.rdata !== e_val) begin
          errors++; $display("FAIL rdata got=%h exp=%h t=%0t", bif.rdata, e_val, $time);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask

  task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] r);
    bit got;
    @(negedge clk);
    bif.valid = 1'b1; bif.addr = a; bif.wstrb = s; bif.wdata = d;
    got = 0; r = 32'hDEAD_BEEF;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (bif.ready === 1'b1) begin got = 1; r = bif.rdata; end
    end
    if (!got) begin
      checks++; errors++; $display("FAIL bus_timeout ready got=0 exp=1 addr=%0d", a);
    end
    @(negedge clk);
    bif.valid = 1'b0; bif.wstrb = 4'h0;
  endtask

  task automatic pulse(input int hi, input int lo);
    @(negedge clk); event_in = 1'b1;
    repeat (hi) @(negedge clk);
    event_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  logic [31:0] r;

  initial begin
    bif.valid = 1'b0; bif.addr = 2'd0; bif.wstrb = 4'h0; bif.wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, bif.ready}, 32'h0);
    chk("reset_rdata", bif.rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // Capture ordering: rising edges, 5 cycles apart
    bus(2'd2, 4'h1, 32'h3, r);
    repeat (3) pulse(2, 3);
    repeat (4) @(negedge clk);
    bus(2'd1, 4'h0, 0, r); chk("order_status", r, 32'h0000_0003);
    repeat (3) bus(2'd0, 4'h0, 0, r);
    bus(2'd1, 4'h0, 0, r); chk("order_empty", r, 32'h0001_0000);

    // Edge select: falling, both, none
    bus(2'd2, 4'h1, 32'h5, r);
    pulse(4, 6);
    bus(2'd1, 4'h0, 0, r); chk("falling_status", r, 32'h0000_0001);
    bus(2'd0, 4'h0, 0, r);
    bus(2'd2, 4'h1, 32'h7, r);
    pulse(4, 6);
    bus(2'd1, 4'h0, 0, r); chk("both_status", r, 32'h0000_0002);
    repeat (2) bus(2'd0, 4'h0, 0, r);
    bus(2'd2, 4'h1, 32'h1, r);
    pulse(4, 6);
    bus(2'd1, 4'h0, 0, r); chk("none_status", r, 32'h0001_0000);

    // Overflow: 10 edges into 8 entries
    bus(2'd2, 4'h1, 32'h3, r);
    repeat (10) pulse(2, 2);
    repeat (4) @(negedge clk);
    bus(2'd1, 4'h0, 0, r); chk("ovf_status", r, 32'h8002_0008);
    repeat (8) bus(2'd0, 4'h0, 0, r);
    bus(2'd1, 4'h8, 32'h8000_0000, r);
    bus(2'd1, 4'h0, 0, r); chk("ovf_cleared", r, 32'h0001_0000);

    // Full FIFO: push lands on the same edge as the DATA pop
    repeat (8) pulse(2, 2);
    repeat (4) @(negedge clk);
    @(negedge clk); event_in = 1'b1;
    @(negedge clk);
    bus(2'd0, 4'h0, 0, r);
    event_in = 1'b0;
    repeat (4) @(negedge clk);
    bus(2'd1, 4'h0, 0, r); chk("full_pushpop", r, 32'h0002_0008);
    repeat (8) bus(2'd0, 4'h0, 0, r);

    // Empty read, then irq on a single capture
    bus(2'd0, 4'h0, 0, r); chk("empty_read", r, 32'h0);
    bus(2'd2, 4'h1, 32'hB, r);
    pulse(2, 6);
    bus(2'd0, 4'h0, 0, r);
    repeat (3) @(negedge clk);

    // Reset while a request is outstanding
    repeat (9) pulse(1, 2);
    @(negedge clk);
    bif.valid = 1'b1; bif.addr = 2'd1; bif.wstrb = 4'h0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {31'b0, bif.ready}, 32'h0);
    chk("rst_mid_rdata", bif.rdata, 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    bif.valid = 1'b0; reset = 1'b0;
    bus(2'd1, 4'h0, 0, r); chk("rst_reissue", r, 32'h0001_0000);

    // Randomized traffic against the model
    bus(2'd2, 4'h1, 32'hB, r);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin @(negedge clk); event_in = ~event_in; end
        4, 5, 6:    bus(2'd0, 4'h0, 0, r);
        7:          bus(2'd1, 4'h0, 0, r);
        8:          bus(2'd2, 4'h1, 32'($urandom_range(0, 15)) | 32'h1, r);
        default:    bus(2'($urandom_range(0, 3)),
                        ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom, r);
      endcase
    end
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
